// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: valid/ready word in, LSB-first bit stream out with start/last framing.
// Optional macro SER_BACK2BACK_EN lets a new word be accepted during the last bit, skipping IDLE.
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_start,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic             last;

  always_comb begin
    last      = (state == SHIFT) && (bitcnt == LAST_CNT);
`ifdef SER_BACK2BACK_EN
    in_ready  = (state == IDLE) || last;
`else
    in_ready  = (state == IDLE);
`endif
    ser_start = (state == START);
    ser_valid = (state == SHIFT);
    ser_bit   = (state == SHIFT) & shreg[0];
    ser_last  = last;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg  <= in_data;
            bitcnt <= '0;
            state  <= START;
          end
        end
        START: begin
          state <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          if (!last) begin
            bitcnt <= bitcnt + CW'(1);
          end else begin
            // counter cleared on the final bit so it never passes WIDTH-1
            bitcnt <= '0;
            state  <= IDLE;
`ifdef SER_BACK2BACK_EN
            if (in_valid) begin
              shreg <= in_data;
              state <= START;
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-to-serial front end for the bit-serial two's-complement stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per clock.
- Emits a one-cycle ser_start pulse before each word, which drives the downstream complementer's synchronous reset so its state is cleared for the new word.
- Also emits a framing strobe on the last bit so a downstream collector can close the word.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  parallel word; sampled on an accepted handshake.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- ser_bit  output  1  serial data bit, LSB first; feeds the complementer's seqin.
- ser_valid  output  1  ser_bit carries a data bit this cycle.
- ser_start  output  1  one-cycle pulse immediately before bit 0; feeds the complementer's reset.
- ser_last  output  1  ser_bit is bit WIDTH-1 of the current word.
- busy  output  1  high in START or SHIFT.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Internal registers:
  - state: IDLE, START, SHIFT.
  - shreg: WIDTH bits.
  - bitcnt: $clog2(WIDTH) bits.
- All outputs decode combinationally from registered state only (Moore). No input-to-output combinational path except in_ready under SER_BACK2BACK_EN.
- Reset: state=IDLE, shreg=0, bitcnt=0.
  - Outputs after reset: in_ready=1, ser_bit=0, ser_valid=0, ser_start=0, ser_last=0, busy=0.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge: shreg<=in_data, bitcnt<=0, state<=START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - ser_start=1, ser_valid=0, ser_bit=0, in_ready=0.
  - Next state is SHIFT.
  - Downstream samples ser_start as reset at this edge, so its state is S0 during bit 0.
- SHIFT (exactly WIDTH cycles):
  - ser_valid=1, ser_bit=shreg[0], in_ready=0.
  - Each edge: shreg<=shreg>>1 with 0 shifted in at the MSB, bitcnt<=bitcnt+1.
  - ser_last=1 when bitcnt==WIDTH-1.
  - On the edge ending the ser_last cycle: state<=IDLE.
- Latency and throughput:
  - Handshake edge to bit 0 on ser_bit: 2 cycles.
  - Word period: WIDTH+2 cycles (IDLE, START, WIDTH x SHIFT).
- No backpressure on the serial side: once accepted, a word always streams to completion.
- Changes to in_data or in_valid during START or SHIFT are ignored.
- Reset asserted mid-word: the word is aborted at that edge, state goes to IDLE with reset values, and no ser_last is emitted for the aborted word.
- Reset and in_valid high in the same cycle: reset wins and the word is not accepted.
- bitcnt never exceeds WIDTH-1; no wrap-around is possible.

Optional Feature:
- Macro: SER_BACK2BACK_EN.
- Defined:
  - in_ready is also 1 during the ser_last SHIFT cycle.
  - If in_valid=1 in that cycle: shreg<=in_data, bitcnt<=0, state<=START, skipping IDLE. Word period becomes WIDTH+1 cycles.
  - If in_valid=0 in that cycle: go to IDLE as normal.
- Not defined:
  - in_ready=1 only in IDLE.
  - Word period fixed at WIDTH+2 cycles.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1, in_data=8'hFF -> all outputs at reset values, in_ready=1, and no START entered.
- Single word (WIDTH=8): in_data=8'h06 accepted at edge T.
  - Required: ser_start=1 in cycle T+1.
  - Required: bits 0,1,1,0,0,0,0,0 with ser_valid=1 in cycles T+2..T+9, ser_last=1 only in T+9, in_ready=1 again in T+10.
  - Chained into the complementer, the collected output is 8'hFA.
- Hold-off: in_valid held at 1 with data 8'hA5 then 8'h3C.
  - Required: second word accepted only in IDLE.
  - Required: exactly one ser_start per word, stream 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, period 10 cycles.
- Ignored input: change in_data to 8'h00 during SHIFT of word 8'h81 -> stream still 1,0,0,0,0,0,0,1.
- Mid-word reset: reset asserted during bit 3 of 8'hF0 -> next cycle IDLE with outputs at reset values, no ser_last seen; the next word 8'h01 then streams correctly.
- SER_BACK2BACK_EN defined: in_valid held high with 8'h01 then 8'h80.
  - Required: second word accepted in the ser_last cycle of the first, and ser_start of word 2 immediately follows ser_last of word 1.
  - Required: period 9 cycles.
